// File: rtl/rv32i_lsu_if.sv
// rtl/rv32i_lsu_if.sv - decoder request, memory port and writeback response bundle for rv32i_lsu
interface rv32i_lsu_if #(
   parameter int XLEN = 32
);
   logic            reqValid;
   logic            reqReady;
   logic            isLoad;
   logic            isStore;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1Val;
   logic [XLEN-1:0] rs2Val;
   logic [XLEN-1:0] imm;
   logic [4:0]      rdIn;

   logic            memReq;
   logic [XLEN-1:0] memAddr;
   logic [XLEN-1:0] memWData;
   logic [3:0]      memWMask;
   logic            memRStrb;
   logic            memAck;
   logic [XLEN-1:0] memRData;

   logic            rspValid;
   logic            rspReady;
   logic [XLEN-1:0] rspData;
   logic [4:0]      rspRd;
   logic            rspErr;

   // Environment side: decoder, memory and writeback
   modport master (
      output reqValid, isLoad, isStore, funct3, rs1Val, rs2Val, imm, rdIn,
      input  reqReady,
      input  memReq, memAddr, memWData, memWMask, memRStrb,
      output memAck, memRData,
      input  rspValid, rspData, rspRd, rspErr,
      output rspReady
   );

   // Load/store unit side
   modport slave (
      input  reqValid, isLoad, isStore, funct3, rs1Val, rs2Val, imm, rdIn,
      output reqReady,
      output memReq, memAddr, memWData, memWMask, memRStrb,
      input  memAck, memRData,
      output rspValid, rspData, rspRd, rspErr,
      input  rspReady
   );
endinterface

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - RV32I load/store unit; define RV32I_LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module rv32i_lsu #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input logic        clk,
   input logic        rst,
   rv32i_lsu_if.slave bus
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

   state_t          state, state_d;
   logic [1:0]      lane, lane_d;
   logic [2:0]      f3, f3_d;
   logic            load, load_d;
   logic [4:0]      rd, rd_d;
   logic [CW-1:0]   cnt, cnt_d;

   logic            mem_req, mem_req_d;
   logic [XLEN-1:0] mem_addr, mem_addr_d;
   logic [XLEN-1:0] mem_wdata, mem_wdata_d;
   logic [3:0]      mem_wmask, mem_wmask_d;
   logic            mem_rstrb, mem_rstrb_d;
   logic            rsp_valid, rsp_valid_d;
   logic [XLEN-1:0] rsp_data, rsp_data_d;
   logic [4:0]      rsp_rd, rsp_rd_d;
   logic            rsp_err, rsp_err_d;

   logic [XLEN-1:0] ea;
   logic [XLEN-1:0] store_data;
   logic [3:0]      store_mask;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_val;
   logic            f3_legal;
   logic            misalign_trap;

   assign ea = bus.rs1Val + bus.imm;

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
   assign misalign_trap = ((bus.funct3[1:0] == 2'd1) && ea[0]) ||
                          ((bus.funct3[1:0] == 2'd2) && (ea[1:0] != 2'b00));
`else
   assign misalign_trap = 1'b0;
`endif

   // Legal funct3 set depends on whether the offered op is a load or a store
   always_comb begin
      f3_legal = 1'b0;
      if (bus.isLoad) f3_legal = bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      else            f3_legal = bus.funct3 inside {3'd0, 3'd1, 3'd2};
   end

   // Byte lane enables and lane-replicated write data for a store
   always_comb begin
      store_mask = 4'b1111;
      store_data = bus.rs2Val;
      case (bus.funct3[1:0])
         2'd0: begin
            store_mask = 4'b0001 << ea[1:0];
            store_data = {4{bus.rs2Val[7:0]}};
         end
         2'd1: begin
            store_mask = 4'b0011 << ea[1:0];
            store_data = {2{bus.rs2Val[15:0]}};
         end
         default: ;
      endcase
   end

   // Align the returned word to the addressed byte, then extend by size and sign
   always_comb begin
      shifted = bus.memRData >> {lane, 3'b000};
      case (f3)
         3'd0:    load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'd1:    load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'd4:    load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'd5:    load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   // Next-state and next-output logic for IDLE / MEM / RESP
   always_comb begin
      state_d     = state;
      lane_d      = lane;
      f3_d        = f3;
      load_d      = load;
      rd_d        = rd;
      cnt_d       = cnt;
      mem_req_d   = mem_req;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_wmask_d = mem_wmask;
      mem_rstrb_d = mem_rstrb;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;
      rsp_rd_d    = rsp_rd;
      rsp_err_d   = rsp_err;
      case (state)
         IDLE: begin
            if (bus.reqValid) begin
               if (bus.isLoad && bus.isStore) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
                  rsp_rd_d    = '0;
               end else if (bus.isLoad || bus.isStore) begin
                  lane_d = ea[1:0];
                  f3_d   = bus.funct3;
                  load_d = bus.isLoad;
                  rd_d   = bus.rdIn;
                  if (!f3_legal || misalign_trap) begin
                     state_d     = RESP;
                     rsp_valid_d = 1'b1;
                     rsp_err_d   = 1'b1;
                     rsp_data_d  = '0;
                     rsp_rd_d    = '0;
                  end else begin
                     state_d     = MEM;
                     cnt_d       = '0;
                     mem_req_d   = 1'b1;
                     mem_addr_d  = {ea[XLEN-1:2], 2'b00};
                     mem_rstrb_d = bus.isLoad;
                     mem_wmask_d = bus.isLoad ? 4'b0000 : store_mask;
                     mem_wdata_d = bus.isLoad ? '0 : store_data;
                  end
               end
               // neither flag set: request consumed silently
            end
         end
         MEM: begin
            // an ack on the final allowed cycle still completes the access
            if (bus.memAck) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               mem_rstrb_d = 1'b0;
               mem_wmask_d = 4'b0000;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = load ? load_val : '0;
               rsp_rd_d    = load ? rd : 5'd0;
            end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               mem_rstrb_d = 1'b0;
               mem_wmask_d = 4'b0000;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
               rsp_rd_d    = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         RESP: begin
            if (bus.rspReady) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any access without a response
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lane      <= '0;
         f3        <= '0;
         load      <= 1'b0;
         rd        <= '0;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_rd    <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_d;
         lane      <= lane_d;
         f3        <= f3_d;
         load      <= load_d;
         rd        <= rd_d;
         cnt       <= cnt_d;
         mem_req   <= mem_req_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_wmask <= mem_wmask_d;
         mem_rstrb <= mem_rstrb_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_rd    <= rsp_rd_d;
         rsp_err   <= rsp_err_d;
      end
   end

   assign bus.reqReady = (state == IDLE) && !rst;
   assign bus.memReq   = mem_req;
   assign bus.memAddr  = mem_addr;
   assign bus.memWData = mem_wdata;
   assign bus.memWMask = mem_wmask;
   assign bus.memRStrb = mem_rstrb;
   assign bus.rspValid = rsp_valid;
   assign bus.rspData  = rsp_data;
   assign bus.rspRd    = rsp_rd;
   assign bus.rspErr   = rsp_err;
endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit for the RV32I core, directly downstream of the instruction decoder. It accepts one decoded load or store at a time, forms the effective address, and drives a single-outstanding word-wide memory port with byte masks. It returns sign- or zero-extended load data, or an error, to writeback through a valid/ready response channel.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `MEM_TIMEOUT`, 16: maximum cycles `memReq` may be held waiting for `memAck` before the access is aborted.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqValid` in 1: a decoded instruction is offered.
- `reqReady` out 1: the unit can accept an instruction.
- `isLoad` in 1: load instruction, from the decoder.
- `isStore` in 1: store instruction, from the decoder.
- `funct3` in 3: access size and sign, from the decoder.
- `rs1Val` in 32: base register value.
- `rs2Val` in 32: store data register value.
- `imm` in 32: `iImm` for loads, `sImm` for stores; the caller selects which.
- `rdIn` in 5: load destination register.
- `memReq` out 1: memory access active.
- `memAddr` out 32: word-aligned address, `{ea[31:2],2'b00}`.
- `memWData` out 32: store data replicated across lanes.
- `memWMask` out 4: byte write enables; `0000` for loads.
- `memRStrb` out 1: read strobe, 1 for loads.
- `memAck` in 1: access complete; `memRData` is valid in the same cycle.
- `memRData` in 32: read word.
- `rspValid` out 1: response available.
- `rspReady` in 1: writeback accepts the response.
- `rspData` out 32: extended load data; 0 for stores and errors.
- `rspRd` out 5: destination register; 0 for stores.
- `rspErr` out 1: misaligned access, illegal `funct3`, or timeout.

## Operation
- FSM states: IDLE, MEM, RESP.
- **IDLE:** `reqReady=1`. The unit accepts on `reqValid&reqReady`.
  - If exactly one of `isLoad`/`isStore` is set: latch all request fields and compute `ea = rs1Val+imm` (mod 2^32, carry discarded).
  - If neither flag is set: the request is consumed and dropped with no response.
  - If both flags are set: go to RESP with `rspErr=1`.
  - Legal `funct3` for loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Legal `funct3` for stores: 0 SB, 1 SH, 2 SW.
  - An illegal `funct3` goes to RESP with `rspErr=1` and no bus access.
  - A legal access goes to MEM. If `RV32I_LSU_MISALIGN_TRAP_EN` is defined and the access is misaligned, it goes to RESP with `rspErr=1` instead.
- **MEM:** `memReq=1`. Address, mask, data and strobe are held stable until `memAck`.
  - Store mask: SB `0001<<ea[1:0]`, SH `0011<<ea[1:0]`, SW `1111`; the shifted mask is truncated to 4 bits.
  - Store data: SB `{4{rs2[7:0]}}`, SH `{2{rs2[15:0]}}`, SW `rs2`.
  - On `memAck`, load data is `memRData >> (8*ea[1:0])`. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend. The result goes to RESP.
  - A cycle counter starts at 0 on entry. If it reaches `MEM_TIMEOUT` without `memAck`, drop `memReq` and go to RESP with `rspErr=1`.
  - A `memAck` arriving in the same cycle the counter reaches `MEM_TIMEOUT` wins: the access completes normally.
  - `memAck` received outside MEM is ignored.
- **RESP:** `rspValid=1`; `rspData`/`rspRd`/`rspErr` are held until `rspReady`, then the FSM returns to IDLE. `reqReady=0` in RESP, so there is no same-cycle accept.
- **Reset:** on `rst`, go to IDLE. All registered outputs become 0 (`memReq`, `memAddr`, `memWData`, `memWMask`, `memRStrb`, `rspValid`, `rspData`, `rspRd`, `rspErr`). `reqReady=0` while `rst` is high.
  - Reset mid-access abandons the access with no response; `memReq` is low after the reset edge.

## Timing
- Accept at edge T0 → `memReq` high in cycle T0+1.
- `memAck` sampled at edge Tn → `rspValid` high from Tn+1.
- Minimum load/store latency: `rspValid` 2 cycles after accept, when `memAck` arrives in the first MEM cycle.
- Error path with no bus access: `rspValid` 1 cycle after accept.
- Timeout: `memReq` is high for exactly `MEM_TIMEOUT` cycles, then `rspValid` rises the next cycle.
- Throughput: at most one instruction per 3 cycles.

## Configuration
- `RV32I_LSU_MISALIGN_TRAP_EN` defined: a misaligned access returns `rspErr=1` with no memory access.
  - Misaligned means LH/LHU/SH with `ea[0]=1`, or LW/SW with `ea[1:0]!=0`.
- Undefined: misaligned accesses proceed on the aligned word.
  - Mask is shifted and truncated to 4 bits.
  - Load data is shifted right by `8*ea[1:0]`, with upper bytes zero before extension.
  - `rspErr` is never set for misalignment.

## Test plan
- LW with `rs1Val=0x1000`, `imm=4`, `memRData=0xDEADBEEF`, ack in the first MEM cycle → `memAddr=0x1004`, `memRStrb=1`, `rspData=0xDEADBEEF`, `rspValid` 2 cycles after accept.
- LB at `ea=0x2003`, `memRData=0x80FF0000` → `rspData=0xFFFFFF80`. LBU at the same address → `0x00000080`.
- SH at `ea=0x3002`, `rs2Val=0x1234ABCD` → `memWMask=1100`, `memWData=0xABCDABCD`, `rspData=0`, `rspRd=0`.
- LW at `ea=0x4001`:
  - With the macro defined → no `memReq`, `rspErr=1` one cycle after accept.
  - Without the macro → `memAddr=0x4000`; with `memRData=0x11223344`, `rspData=0x00112233`.
- No `memAck` with `MEM_TIMEOUT=16` → `memReq` high for 16 cycles, then `rspErr=1`.
- Backpressure: hold `rspReady=0` for 5 cycles → response held stable and `reqReady=0`. Assert `rst` during MEM → `memReq=0` after the edge and no response.
